// File: rtl/mdu_pkg.sv
// Shared MDU definitions, used by the ID/EX decoder, the hazard unit and the
// MDU itself.
//   mdu_op_e      : MDUOp operation codes 0..8. Codes 9..15 behave as none.
//   mdu_state_e   : idle/busy state of the multi-cycle engine.
//   MULT_CYC_DEF  : default busy cycles for mult/multu.
//   DIV_CYC_DEF   : default busy cycles for div/divu.
//   mdu_is_start(): 1 for the codes that launch a multi-cycle operation.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  function automatic logic mdu_is_start(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> MDU signal bundle.
//   A, B    : forwarded rs/rt operands
//   MDUOp   : operation code (see mdu_pkg::mdu_op_e)
//   Req     : exception/interrupt cancels the EX instruction
//   Start   : MDUOp is a mult/div code (combinational)
//   Busy    : mult/div in progress (registered)
//   Out     : mfhi/mflo read data (combinational)
//   HI, LO  : architectural HI/LO registers
// master = EX stage / pipeline side, slave = the MDU.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDUOp, Req,
    input  Start, Busy, Out, HI, LO
  );

  modport slave (
    input  A, B, MDUOp, Req,
    output Start, Busy, Out, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit of the EX stage. Owns HI/LO, runs mult/multu/div/divu
// as a fixed-length busy period, and serves mfhi/mflo/mthi/mtlo.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears HI/LO, pending result, counter
//   bus   : mdu_if.slave (A, B, MDUOp, Req in; Start, Busy, Out, HI, LO out)
// Parameters:
//   MULT_CYC : busy cycles for mult/multu
//   DIV_CYC  : busy cycles for div/divu
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      phi_q;
  logic [31:0]      plo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  // Datapath: all results computed combinationally from the current operands
  // and captured into pHI/pLO on the accepting edge.
  always_comb begin
    prod_s  = 64'($signed(bus.A)) * 64'($signed(bus.B));
    prod_u  = 64'(bus.A) * 64'(bus.B);
    // A zero divisor is replaced by 1 only to keep the divider well defined;
    // those results are never written (see the accept logic).
    divisor = (bus.B == '0) ? 32'd1 : bus.B;
    // Division by -1 is done as negation so 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of overflowing the divider.
    if (bus.B == '1) begin
      sq = 32'd0 - bus.A;
      sr = '0;
    end else begin
      sq = $signed(bus.A) / $signed(divisor);
      sr = $signed(bus.A) % $signed(divisor);
    end
    uq = bus.A / divisor;
    ur = bus.A % divisor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_q  <= phi_q;
            lo_q  <= plo_q;
            state <= ST_IDLE;
          end
        end
        default: begin
          if (!bus.Req) begin
            case (bus.MDUOp)
              MDU_MULT: begin
                {phi_q, plo_q} <= prod_s;
                cnt_q          <= CNT_W'(MULT_CYC);
                state          <= ST_BUSY;
              end
              MDU_MULTU: begin
                {phi_q, plo_q} <= prod_u;
                cnt_q          <= CNT_W'(MULT_CYC);
                state          <= ST_BUSY;
              end
              // Divide by zero still runs the full busy period; the pending
              // result is preloaded with the current HI/LO, which cannot
              // change while busy, so completion leaves them unchanged.
              MDU_DIV: begin
                phi_q <= (bus.B == '0) ? hi_q : sr;
                plo_q <= (bus.B == '0) ? lo_q : sq;
                cnt_q <= CNT_W'(DIV_CYC);
                state <= ST_BUSY;
              end
              MDU_DIVU: begin
                phi_q <= (bus.B == '0) ? hi_q : ur;
                plo_q <= (bus.B == '0) ? lo_q : uq;
                cnt_q <= CNT_W'(DIV_CYC);
                state <= ST_BUSY;
              end
              MDU_MTHI: hi_q <= bus.A;
              MDU_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    case (bus.MDUOp)
      MDU_MFHI: bus.Out = hi_q;
      MDU_MFLO: bus.Out = lo_q;
      default:  bus.Out = '0;
    endcase
  end

  assign bus.Start = mdu_is_start(bus.MDUOp);
  assign bus.Busy  = (state == ST_BUSY);
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit of the EX stage, consuming the `MDUOp` code and the forwarded register operands produced by the ID/EX pipeline register. It owns the architectural HI/LO registers and executes mult/multu/div/divu over multiple cycles, reporting `Start`/`Busy` so hazard logic can stall later HI/LO-dependent instructions. It also serves mfhi/mflo reads and mthi/mtlo writes, and suppresses new side effects when the EX instruction is cancelled by an exception or interrupt.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu.
- `DIV_CYC`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `A`  in  32  operand rs, already forwarded.
- `B`  in  32  operand rt, already forwarded.
- `MDUOp`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none.
- `Req`  in  1  exception/interrupt request for the EX instruction; when 1, no operation starts and no HI/LO write occurs.
- `Start`  out  1  combinational; 1 when `MDUOp` is 1–4, regardless of `Req` and `Busy`.
- `Busy`  out  1  registered; 1 while a mult/div is in progress.
- `Out`  out  32  combinational; HI when `MDUOp`=5, LO when 6, else 0.
- `HI`, `LO`  out  32 each  current architectural values.

## Operation
- State: `HI`, `LO`, pending result `pHI`/`pLO` (32 each), countdown `cnt`, `Busy`.
- Accept condition: `MDUOp` is 1–4, `Req`=0 and `Busy`=0. On the accepting edge:
  - compute the result into `pHI`/`pLO`;
  - load `cnt` with `MULT_CYC` or `DIV_CYC`;
  - set `Busy`=1.
- While `Busy`=1, `cnt` decrements each edge. On the edge where `cnt`=1:
  - HI←`pHI`, LO←`pLO`, `Busy`←0.
- mult: {HI,LO} = signed A × signed B, full 64-bit product.
- multu: {HI,LO} = unsigned A × unsigned B.
- div:
  - LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, unsigned remainder in HI.
- Divide by zero (B=0, div or divu): full busy period runs; HI and LO are left unchanged at completion.
- mthi/mtlo (`Req`=0, `Busy`=0): HI←A or LO←A at the edge.
- mthi/mtlo with `Busy`=1: ignored. Hazard logic guarantees this never occurs; the block does not rely on it.
- Any op with `Req`=1: no state change. An in-flight operation continues and completes normally.
- New mult/div with `Busy`=1: ignored.

## Timing
- Reset (asynchronous): HI=LO=pHI=pLO=0, cnt=0, Busy=0.
- Reset mid-operation drops the pending result; HI/LO read 0 afterwards.
- mult accepted in cycle T:
  - `Start`=1 in T;
  - `Busy`=1 in T+1..T+5;
  - HI/LO updated at the end of T+5;
  - `Busy`=0 and the new values visible from T+6.
- div: same pattern with 10 busy cycles, T+1..T+10; results visible from T+11.
- mthi/mtlo in T: new value visible in T+1.
- mfhi/mflo: `Out` is combinational, zero latency. During `Busy`, `Out` returns the old HI/LO; stall logic prevents that read.
- Back-to-back operations: a new op may be accepted in the first cycle with `Busy`=0, i.e. T+6 after a mult.

## Structure
- Shared header, used with the ID/EX decoder and hazard unit, holds:
  - `MDUOp` code constants 0–8;
  - default cycle counts 5 and 10.
- Single module, no sub-modules. Products and quotients use Verilog `*`, `/` and `%` on signed/unsigned casts; counter and latching logic are inline.

## Test plan
- Reset, then mthi A=0x12345678; next cycle `MDUOp`=5 → `Out`=0x12345678, `Busy`=0.
- mult A=0xFFFFFFFE (−2), B=3 → `Busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → `Busy` high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with B=0 after mtlo 0x55 and mthi 0xAA → `Busy` high 10 cycles; LO stays 0x55, HI stays 0xAA.
- mult presented with `Req`=1 → `Start`=1 but `Busy` stays 0 and HI/LO are unchanged.
- div accepted, then `reset` asserted asynchronously in busy cycle 4 → `Busy`=0 and HI=LO=0 immediately, and they stay 0 after reset releases.
